// File: rtl/regfile_dump.sv
// regfile_dump
//   Read-side dump engine for the CPU register file. A start pulse walks an
//   inclusive index range [start_addr..end_addr], wrapping modulo
//   2**ADDRESS_WIDTH, through a spare asynchronous read port. Each value is
//   presented on a valid/ready stream together with its index. The engine
//   never writes the register file, so words reflect the storage contents in
//   the cycle each one is read (not an atomic snapshot).
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       begin a dump (sampled only while idle)
//   abort       synchronous cancel, returns to idle without a done pulse
//   start_addr  first index, latched when start is accepted
//   end_addr    last index (inclusive), latched when start is accepted
//   rd_addr     index presented to the register-file read port
//   rd_data     combinational read data for rd_addr
//   out_valid   out_data/out_index hold a word
//   out_ready   consumer accepts the word when out_valid && out_ready
//   out_data    captured register value
//   out_index   index of out_data
//   busy        high from accepted start until done or abort
//   done        one-cycle pulse after the last word is accepted
module regfile_dump #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter bit ZERO_X0       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH-1:0] end_addr,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ADDRESS_WIDTH-1:0] out_index,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] ptr;
  logic [ADDRESS_WIDTH-1:0] end_ptr;

  // x0 is architecturally zero; hide whatever the storage happens to hold.
  function automatic logic [DATA_WIDTH-1:0] zero_mask(
    input logic [ADDRESS_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0]    d
  );
    if (ZERO_X0 && (idx == '0)) begin
      return '0;
    end
    return d;
  endfunction

  // The read port always follows the walk pointer; it is only consumed in READ.
  assign rd_addr = ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      end_ptr   <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      // Abort outranks handshakes and completion in every active state.
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr     <= start_addr;
            end_ptr <= end_addr;
            busy    <= 1'b1;
            state   <= S_READ;
          end
        end
        // READ -> SEND: capture the asynchronous read data for the current index.
        S_READ: begin
          out_data  <= zero_mask(ptr, rd_data);
          out_index <= ptr;
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        // SEND: hold the word until accepted, then step or finish.
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ptr == end_ptr) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              ptr   <= ptr + ADDR_ONE;
              state <= S_READ;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
